nibble_serial_addsub: RTL and testbench

// - Multi-word add/subtract sequencer built around the 4-bit ripple-carry adder slice.
// - Feeds the slice one operand nibble per cycle, LSB first, and carries between nibbles in a register.
// - Assembles the WIDTH-bit result and reports cout, signed overflow and zero.
// - Sits between the operand source and the result consumer; valid/ready handshake on both sides.

---
 rtl/nibble_serial_addsub.sv | 127 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract: streams operands through a 4-bit ripple-carry slice one
// nibble per cycle (LSB first) with a registered inter-nibble carry.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IW-1:0]      r_idx;
    logic [WIDTH-1:0]   r_q;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;

    logic [3:0]         w_a_nib [N];
    logic [3:0]         w_b_nib [N];
    logic [3:0]         w_a_sel;
    logic [3:0]         w_b_sel;
    logic [3:0]         w_sum;
    logic [4:0]         w_c;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_last;
    logic               w_accept;
    logic               w_release;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_nib
            assign w_a_nib[gi] = r_a[4*gi +: 4];
            assign w_b_nib[gi] = r_b[4*gi +: 4];
            // Only the nibble being computed this cycle is replaced.
            assign w_q_next[4*gi +: 4] = (r_idx == IW'(gi)) ? w_sum : r_q[4*gi +: 4];
        end
    endgenerate

    assign w_a_sel = w_a_nib[r_idx];
    assign w_b_sel = w_b_nib[r_idx];

    // 4-bit ripple-carry slice
    assign w_c[0] = r_carry;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign w_sum[gi]  = w_a_sel[gi] ^ w_b_sel[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (w_a_sel[gi] & w_b_sel[gi]) | (w_c[gi] & (w_a_sel[gi] ^ w_b_sel[gi]));
        end
    endgenerate

    assign w_last    = (r_idx == IW'(N - 1));
    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_release = (r_state == DONE) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_q     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert B once and seed the carry with sub.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_q     <= w_q_next;
            r_carry <= w_c[4];
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_c[4];
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);
                r_zero <= (w_q_next == '0);
            end
        end else if (w_release) begin
            r_idx   <= '0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign q         = r_q;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub: vector table plus backpressure and mid-run reset sequences.
module tb_nibble_serial_addsub;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic        sub_drv;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        cout;
    logic        ovf;
    logic        zero;

    int total = 0;
    int bad   = 0;

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_drv),
        .b         (b_drv),
        .sub       (sub_drv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] q;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, optionally stall the output for `hold` cycles while
    // presenting a competing request, then complete the output handshake.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         input int hold,
                         output logic [15:0] rq, output logic rc, output logic ro, output logic rz);
        int cyc;
        @(negedge clk);
        a_drv = ta; b_drv = tb; sub_drv = ts; in_valid = 1'b1;
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_drv = ~ta; b_drv = 16'h5A5A; sub_drv = ~ts;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 32'd4);
        rq = q; rc = cout; ro = ovf; rz = zero;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; a_drv = 16'h1111 * h[15:0]; b_drv = 16'h0F0F; sub_drv = h[0];
            @(posedge clk); #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            check("bp_q", {16'd0, q}, {16'd0, rq});
            check("bp_flags", {29'd0, cout, ovf, zero}, {29'd0, rc, ro, rz});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] rq;
        logic        rc, ro, rz;

        vecs[0]  = '{a:16'h1234, b:16'h0FFF, sub:1'b0, q:16'h2233, c:1'b0, o:1'b0, z:1'b0};
        vecs[1]  = '{a:16'hFFFF, b:16'h0001, sub:1'b0, q:16'h0000, c:1'b1, o:1'b0, z:1'b1};
        vecs[2]  = '{a:16'h0005, b:16'h0007, sub:1'b1, q:16'hFFFE, c:1'b0, o:1'b0, z:1'b0};
        vecs[3]  = '{a:16'h7FFF, b:16'h0001, sub:1'b0, q:16'h8000, c:1'b0, o:1'b1, z:1'b0};
        vecs[4]  = '{a:16'h8000, b:16'h0001, sub:1'b1, q:16'h7FFF, c:1'b1, o:1'b1, z:1'b0};
        vecs[5]  = '{a:16'h0000, b:16'h0000, sub:1'b0, q:16'h0000, c:1'b0, o:1'b0, z:1'b1};
        vecs[6]  = '{a:16'h1234, b:16'h1234, sub:1'b1, q:16'h0000, c:1'b1, o:1'b0, z:1'b1};
        vecs[7]  = '{a:16'h8000, b:16'h8000, sub:1'b0, q:16'h0000, c:1'b1, o:1'b1, z:1'b1};
        vecs[8]  = '{a:16'h0000, b:16'h0001, sub:1'b1, q:16'hFFFF, c:1'b0, o:1'b0, z:1'b0};
        vecs[9]  = '{a:16'hABCD, b:16'h1111, sub:1'b0, q:16'hBCDE, c:1'b0, o:1'b0, z:1'b0};
        vecs[10] = '{a:16'h00FF, b:16'h0001, sub:1'b0, q:16'h0100, c:1'b0, o:1'b0, z:1'b0};
        vecs[11] = '{a:16'h9000, b:16'h7000, sub:1'b1, q:16'h2000, c:1'b1, o:1'b1, z:1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_drv = '0; b_drv = '0; sub_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q", {16'd0, q}, 32'd0);
        check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, rq, rc, ro, rz);
            check("vec_q", {16'd0, rq}, {16'd0, vecs[i].q});
            check("vec_cout", {31'd0, rc}, {31'd0, vecs[i].c});
            check("vec_ovf", {31'd0, ro}, {31'd0, vecs[i].o});
            check("vec_zero", {31'd0, rz}, {31'd0, vecs[i].z});
            $display("vec %0d: %h %s %h -> q=%h c=%b o=%b z=%b (exp q=%h c=%b o=%b z=%b)",
                     i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b, rq, rc, ro, rz,
                     vecs[i].q, vecs[i].c, vecs[i].o, vecs[i].z);
        end

        // Backpressure: 10 stalled cycles with a competing request, then a fresh op.
        do_op(16'h1234, 16'h0FFF, 1'b0, 10, rq, rc, ro, rz);
        check("bp_result_q", {16'd0, rq}, 32'h2233);
        $display("backpressure: q=%h c=%b o=%b z=%b", rq, rc, ro, rz);
        do_op(16'h0005, 16'h0007, 1'b1, 0, rq, rc, ro, rz);
        check("post_bp_q", {16'd0, rq}, 32'hFFFE);
        check("post_bp_cout", {31'd0, rc}, 32'd0);
        $display("after backpressure: q=%h c=%b", rq, rc);

        // Reset while RUN is at nibble index 2.
        @(negedge clk);
        a_drv = 16'h7777; b_drv = 16'h1111; sub_drv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_q", {16'd0, q}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-run reset: out_valid=%b q=%h in_ready=%b", out_valid, q, in_ready);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, rq, rc, ro, rz);
        check("post_rst_q", {16'd0, rq}, 32'h8000);
        check("post_rst_ovf", {31'd0, ro}, 32'd1);
        $display("after reset: q=%h c=%b o=%b z=%b", rq, rc, ro, rz);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
